// File: rtl/fetch_unit_if.sv
// Instruction-memory request channel between the fetch stage and instruction memory.
// Latency: none, this only bundles wires.
// Backpressure: the master holds req/addr until gnt; one response per grant, in order.
// Ports: req/addr from fetch; gnt, rvalid and rdata from memory.
interface fetch_unit_if;
    logic        req;     // fetch request valid
    logic [31:0] addr;    // word address (current PC)
    logic        gnt;     // request accepted this cycle
    logic        rvalid;  // read data valid, at least one cycle after gnt
    logic [31:0] rdata;   // instruction word

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches one word at a time and fills the IF/ID register.
// Latency: gnt in REQ, rvalid the next cycle -> IF/ID loads one cycle later (1 instr / 2 cycles).
// Backpressure: stall_IF freezes IF/ID; a response arriving under stall is parked in a hold buffer.
// Ports: clk, rst (async, active low), stall_IF, pc_next_sel/branch_jump_addr (redirect),
//        imem (fetch_unit_if.master), IF/ID outputs pc_ID/pcPlus4_ID/instr_ID/valid_ID,
//        fetch_misalign (sticky flag).
// Build option: define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets and halt;
//        otherwise targets are word-aligned by clearing bits [1:0] and fetch_misalign is 0.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_IF,
    input  logic         pc_next_sel,
    input  logic [31:0]  branch_jump_addr,
    fetch_unit_if.master imem,
    output logic [31:0]  pc_ID,
    output logic [31:0]  pcPlus4_ID,
    output logic [31:0]  instr_ID,
    output logic         valid_ID,
    output logic         fetch_misalign
);

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP, S_HALT} state_t;
`else
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc4_id_q, pc4_id_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic        valid_id_q, valid_id_d;
    logic        misalign_q, misalign_d;

    // Redirect decode. redir is an accepted redirect that loads the PC.
    logic        redir;
    logic        misalign_hit;
    logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_CHK_EN
    logic halted;
    assign halted       = (state_q == S_HALT);
    assign misalign_hit = pc_next_sel && !halted && (branch_jump_addr[1:0] != 2'b00);
    assign redir        = pc_next_sel && !halted && (branch_jump_addr[1:0] == 2'b00);
    assign redir_tgt    = branch_jump_addr;
`else
    assign misalign_hit = 1'b0;
    assign redir        = pc_next_sel;
    assign redir_tgt    = {branch_jump_addr[31:2], 2'b00};
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks stall, gnt and rvalid
    always_comb begin
        state_d = state_q;
        if (redir) begin
            case (state_q)
                // A granted request for the old PC is still in flight: swallow it
                S_REQ:   state_d = imem.gnt    ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem.rvalid ? S_REQ  : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = S_DROP;
                default: state_d = state_q;
            endcase
        end else begin
            case (state_q)
                S_REQ:   if (imem.gnt) state_d = S_WAIT;
                S_WAIT:  if (imem.rvalid) state_d = stall_IF ? S_HOLD : S_REQ;
                S_HOLD:  if (!stall_IF) state_d = S_REQ;
                S_DROP:  if (imem.rvalid) state_d = S_REQ;
                default: state_d = state_q;
            endcase
        end
`ifdef FETCH_MISALIGN_CHK_EN
        if (misalign_hit) state_d = S_HALT;
`endif
    end

    // Output logic; keep req low while reset is asserted even though state sits in REQ
    always_comb begin
        imem.req  = (state_q == S_REQ) && rst;
        imem.addr = pc_q;
    end

    // Datapath next-state: PC, hold buffer, IF/ID register, sticky flag
    logic        load;
    logic [31:0] load_pc;
    logic [31:0] load_instr;

    always_comb begin
        pc_d         = pc_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        pc_id_d      = pc_id_q;
        pc4_id_d     = pc4_id_q;
        instr_id_d   = instr_id_q;
        valid_id_d   = valid_id_q;
        misalign_d   = misalign_q;
        load         = 1'b0;
        load_pc      = pc_q;
        load_instr   = imem.rdata;

        if (redir || misalign_hit) begin
            // Flush IF/ID even under stall; the hold buffer is simply abandoned
            valid_id_d = 1'b0;
            instr_id_d = NOP_INSTR;
            if (redir) pc_d = redir_tgt;
            if (misalign_hit) misalign_d = 1'b1;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (imem.rvalid) begin
                        pc_d = pc_q + 32'd4;
                        if (stall_IF) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = imem.rdata;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_IF) begin
                        load       = 1'b1;
                        load_pc    = hold_pc_q;
                        load_instr = hold_instr_q;
                    end
                end
                default: ;
            endcase

            if (load) begin
                pc_id_d    = load_pc;
                pc4_id_d   = load_pc + 32'd4;
                instr_id_d = load_instr;
                valid_id_d = 1'b1;
            end else if (!stall_IF) begin
                valid_id_d = 1'b0;
                instr_id_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q         <= RESET_PC;
            hold_pc_q    <= 32'h0;
            hold_instr_q <= NOP_INSTR;
            pc_id_q      <= 32'h0;
            pc4_id_q     <= 32'h0;
            instr_id_q   <= NOP_INSTR;
            valid_id_q   <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            pc_id_q      <= pc_id_d;
            pc4_id_q     <= pc4_id_d;
            instr_id_q   <= instr_id_d;
            valid_id_q   <= valid_id_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc_ID          = pc_id_q;
    assign pcPlus4_ID     = pc4_id_q;
    assign instr_ID       = instr_id_q;
    assign valid_ID       = valid_id_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with grant budget and response latency,
// scoreboard of expected IF/ID entries, scenario tasks run in sequence.
// Memory returns rdata = addr ^ 32'hA5A5_0000.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_IF = 1'b0;
    logic        pc_next_sel = 1'b0;
    logic [31:0] branch_jump_addr = 32'h0;
    logic [31:0] pc_ID, pcPlus4_ID, instr_ID;
    logic        valid_ID, fetch_misalign;

    fetch_unit_if mif();

    fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_IF         (stall_IF),
        .pc_next_sel      (pc_next_sel),
        .branch_jump_addr (branch_jump_addr),
        .imem             (mif),
        .pc_ID            (pc_ID),
        .pcPlus4_ID       (pcPlus4_ID),
        .instr_ID         (instr_ID),
        .valid_ID         (valid_ID),
        .fetch_misalign   (fetch_misalign)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int pop_cnt = 0;
    int last_pop_cyc = 0;
    logic [31:0] exp_q[$];
    logic stall_smp = 1'b0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        stall_smp <= stall_IF;
    end

    // Memory model: one outstanding request, grants limited by budget
    int budget = 0;
    int lat = 1;
    bit pend = 0;
    int cnt = 0;
    logic [31:0] paddr = 32'h0;

    initial begin
        mif.gnt = 1'b0; mif.rvalid = 1'b0; mif.rdata = 32'h0;
        forever begin
            @(negedge clk);
            mif.gnt = 1'b0; mif.rvalid = 1'b0;
            if (!rst) begin
                pend = 0;
            end else begin
                if (pend) begin
                    if (cnt <= 1) begin
                        mif.rvalid = 1'b1; mif.rdata = paddr ^ K; pend = 0;
                    end else begin
                        cnt--;
                    end
                end
                if (mif.req && budget > 0) begin
                    mif.gnt = 1'b1; pend = 1; paddr = mif.addr; cnt = lat; budget--;
                end
            end
        end
    end

    // Scoreboard: each freshly loaded IF/ID entry must match the head of exp_q
    always @(negedge clk) begin
        if (rst && valid_ID && !stall_smp) begin
            if (exp_q.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected_valid: pc_ID=%h, required no delivery", pc_ID);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                vecs++;
                if (pc_ID !== e) begin errs++; $display("FAIL sb_pc_ID: got %h, required %h", pc_ID, e); end
                vecs++;
                if (pcPlus4_ID !== e + 32'd4) begin errs++; $display("FAIL sb_pcPlus4_ID: got %h, required %h", pcPlus4_ID, e + 32'd4); end
                vecs++;
                if (instr_ID !== (e ^ K)) begin errs++; $display("FAIL sb_instr_ID: got %h, required %h", instr_ID, e ^ K); end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_empty(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            step();
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        vecs++; if (mif.req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b, required 0", mif.req); end
        vecs++; if (mif.addr !== 32'h0) begin errs++; $display("FAIL rst_addr: got %h, required 0", mif.addr); end
        vecs++; if (valid_ID !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b, required 0", valid_ID); end
        vecs++; if (instr_ID !== NOP) begin errs++; $display("FAIL rst_instr: got %h, required %h", instr_ID, NOP); end
        vecs++; if (pc_ID !== 32'h0) begin errs++; $display("FAIL rst_pc_ID: got %h, required 0", pc_ID); end
        vecs++; if (pcPlus4_ID !== 32'h0) begin errs++; $display("FAIL rst_pcPlus4: got %h, required 0", pcPlus4_ID); end
        vecs++; if (fetch_misalign !== 1'b0) begin errs++; $display("FAIL rst_misalign: got %b, required 0", fetch_misalign); end
    endtask

    task automatic test_stream();
        bit ok;
        int p0, c0;
        lat = 1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        budget = 8;
        p0 = pop_cnt;
        rst = 1'b1;
        c0 = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pop_cnt != p0) begin c0 = last_pop_cyc; break; end
        end
        wait_empty(60, ok);
        vecs++; if (!ok || c0 < 0) begin errs++; $display("FAIL stream_timeout: %0d entries left, required 0", exp_q.size()); end
        vecs++; if (last_pop_cyc - c0 != 14) begin errs++; $display("FAIL stream_rate: 8 entries took %0d cycles, required 14", last_pop_cyc - c0); end
        step(); step();
        vecs++; if (mif.req !== 1'b1) begin errs++; $display("FAIL stream_req: got %b, required 1", mif.req); end
        vecs++; if (mif.addr !== 32'd32) begin errs++; $display("FAIL stream_addr: got %h, required 00000020", mif.addr); end
        vecs++; if (valid_ID !== 1'b0) begin errs++; $display("FAIL stream_idle_valid: got %b, required 0", valid_ID); end
    endtask

    task automatic test_stall();
        bit ok, found;
        exp_q.push_back(32'd32); exp_q.push_back(32'd36);
        budget = 2;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mif.rvalid && mif.rdata == (32'd36 ^ K)) begin found = 1; break; end
        end
        vecs++; if (!found) begin errs++; $display("FAIL stall_no_rvalid: got none, required rvalid for pc 00000024"); end
        stall_IF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++; if (pc_ID !== 32'd32 || pcPlus4_ID !== 32'd36) begin errs++; $display("FAIL stall_hold_pc: got %h/%h, required 00000020/00000024", pc_ID, pcPlus4_ID); end
            vecs++; if (mif.req !== 1'b0) begin errs++; $display("FAIL stall_req: got %b, required 0", mif.req); end
            vecs++; if (valid_ID !== 1'b0) begin errs++; $display("FAIL stall_valid: got %b, required 0", valid_ID); end
        end
        stall_IF = 1'b0;
        wait_empty(10, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL stall_timeout: %0d entries left, required 0", exp_q.size()); end
        step();
        vecs++; if (mif.addr !== 32'd40) begin errs++; $display("FAIL stall_next_addr: got %h, required 00000028", mif.addr); end
    endtask

    task automatic test_redirect_wait();
        bit ok, seen;
        lat = 3;
        budget = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pend) begin seen = 1; break; end
        end
        step();
        vecs++; if (!seen || mif.req !== 1'b0) begin errs++; $display("FAIL redir_wait_setup: req=%b, required in-flight request", mif.req); end
        pc_next_sel = 1'b1; branch_jump_addr = 32'h100;
        lat = 1;
        exp_q.push_back(32'h100);
        budget = 1;
        step();
        pc_next_sel = 1'b0;
        vecs++; if (valid_ID !== 1'b0) begin errs++; $display("FAIL redir_wait_valid: got %b, required 0", valid_ID); end
        vecs++; if (mif.req !== 1'b0) begin errs++; $display("FAIL redir_wait_drop_req: got %b, required 0", mif.req); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (mif.req) begin seen = 1; break; end
            step();
        end
        vecs++; if (!seen || mif.addr !== 32'h100) begin errs++; $display("FAIL redir_wait_addr: got %h req=%b, required 00000100 req=1", mif.addr, mif.req); end
        wait_empty(10, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL redir_wait_timeout: %0d entries left, required 0", exp_q.size()); end
    endtask

    task automatic test_redirect_stall();
        bit ok, seen;
        step();
        budget = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mif.rvalid) begin seen = 1; break; end
        end
        vecs++; if (!seen || mif.rdata !== (32'h104 ^ K)) begin errs++; $display("FAIL redir_stall_setup: rdata %h, required %h", mif.rdata, 32'h104 ^ K); end
        stall_IF = 1'b1; pc_next_sel = 1'b1; branch_jump_addr = 32'h200;
        step();
        stall_IF = 1'b0; pc_next_sel = 1'b0;
        vecs++; if (valid_ID !== 1'b0 || instr_ID !== NOP) begin errs++; $display("FAIL redir_stall_flush: valid=%b instr=%h, required 0/%h", valid_ID, instr_ID, NOP); end
        vecs++; if (mif.req !== 1'b1 || mif.addr !== 32'h200) begin errs++; $display("FAIL redir_stall_addr: req=%b addr=%h, required 1/00000200", mif.req, mif.addr); end
        exp_q.push_back(32'h200);
        budget = 1;
        wait_empty(10, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL redir_stall_timeout: %0d entries left, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        step();
        pc_next_sel = 1'b1; branch_jump_addr = 32'hFFFF_FFFC;
        step();
        pc_next_sel = 1'b0;
        vecs++; if (mif.addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_addr: got %h, required fffffffc", mif.addr); end
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        budget = 2;
        wait_empty(20, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL wrap_timeout: %0d entries left, required 0", exp_q.size()); end
        step();
        vecs++; if (mif.addr !== 32'h4) begin errs++; $display("FAIL wrap_next_addr: got %h, required 00000004", mif.addr); end
    endtask

    task automatic test_misalign();
        bit ok;
        pc_next_sel = 1'b1; branch_jump_addr = 32'h102;
        step();
        pc_next_sel = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        vecs++; if (fetch_misalign !== 1'b1) begin errs++; $display("FAIL mis_flag: got %b, required 1", fetch_misalign); end
        vecs++; if (mif.req !== 1'b0 || valid_ID !== 1'b0) begin errs++; $display("FAIL mis_halt: req=%b valid=%b, required 0/0", mif.req, valid_ID); end
        pc_next_sel = 1'b1; branch_jump_addr = 32'h300;
        budget = 4;
        step();
        pc_next_sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vecs++; if (mif.req !== 1'b0 || valid_ID !== 1'b0) begin errs++; $display("FAIL mis_halt_hold: req=%b valid=%b, required 0/0", mif.req, valid_ID); end
            step();
        end
        vecs++; if (fetch_misalign !== 1'b1) begin errs++; $display("FAIL mis_sticky: got %b, required 1", fetch_misalign); end
        rst = 1'b0;
        budget = 1;
        step();
        vecs++; if (fetch_misalign !== 1'b0) begin errs++; $display("FAIL mis_rst_clear: got %b, required 0", fetch_misalign); end
        exp_q.push_back(32'h0);
        rst = 1'b1;
        wait_empty(10, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL mis_restart_timeout: %0d entries left, required 0", exp_q.size()); end
`else
        vecs++; if (fetch_misalign !== 1'b0) begin errs++; $display("FAIL mis_flag: got %b, required 0", fetch_misalign); end
        vecs++; if (mif.req !== 1'b1 || mif.addr !== 32'h100) begin errs++; $display("FAIL mis_align_addr: req=%b addr=%h, required 1/00000100", mif.req, mif.addr); end
        exp_q.push_back(32'h100);
        budget = 1;
        wait_empty(10, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL mis_align_timeout: %0d entries left, required 0", exp_q.size()); end
`endif
    endtask

    task automatic test_reset_mid();
        lat = 3;
        budget = 1;
        step(); step();
        rst = 1'b0;
        step();
        vecs++; if (mif.req !== 1'b0 || valid_ID !== 1'b0) begin errs++; $display("FAIL midrst_state: req=%b valid=%b, required 0/0", mif.req, valid_ID); end
        lat = 1;
        rst = 1'b1;
        step();
        vecs++; if (mif.req !== 1'b1 || mif.addr !== 32'h0) begin errs++; $display("FAIL midrst_restart: req=%b addr=%h, required 1/00000000", mif.req, mif.addr); end
        step(); step(); step();
        vecs++; if (valid_ID !== 1'b0) begin errs++; $display("FAIL midrst_no_stale: valid=%b, required 0", valid_ID); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000ns, required completion");
        $fatal(1);
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. It is the consumer end of the execute-stage redirect interface (pc_next_sel / branch_jump_addr).
- Owns the PC register and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Drives the IF/ID pipeline register (pc_ID, pcPlus4_ID, instr_ID, valid_ID).
- Squashes wrong-path fetches on redirect and honours the hazard unit's stall.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, instr_ID value when no valid instruction is held (addi x0,x0,0)

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
stall_IF  input  1  hazard unit: hold IF/ID and do not advance PC
pc_next_sel  input  1  execute stage: redirect taken this cycle
branch_jump_addr  input  32  execute stage: redirect target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address (= current PC)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid (in order, ≥1 cycle after gnt)
imem_rdata  input  32  instruction word
pc_ID  output  32  PC of instr_ID
pcPlus4_ID  output  32  pc_ID + 4
instr_ID  output  32  fetched instruction
valid_ID  output  1  instr_ID is a real instruction
fetch_misalign  output  1  sticky misaligned-redirect flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=REQ; imem_req=0 while in reset.
  - valid_ID=0; instr_ID=NOP_INSTR; pc_ID=0; pcPlus4_ID=0; fetch_misalign=0.
- Outstanding requests: at most one. Combinational outputs: imem_req=1 only in state REQ; imem_addr=pc.
- States:
  - REQ: if gnt, go to WAIT. Otherwise stay in REQ.
  - WAIT: on rvalid with !stall_IF:
    - IF/ID <= {pc, pc+4, rdata, valid=1}
    - pc <= pc+4; go to REQ
  - WAIT: on rvalid with stall_IF:
    - capture {pc, rdata} in hold buffer; pc <= pc+4; go to HOLD
  - HOLD: when !stall_IF, move hold buffer to IF/ID (valid=1), then go to REQ.
  - DROP: on rvalid, discard the data and go to REQ.
- Throughput: 1 instruction per 2 cycles with zero-wait-state memory (gnt in REQ, rvalid the next cycle).
- IF/ID register:
  - stall_IF=1: all four outputs hold.
  - stall_IF=0 and no instruction delivered: valid_ID<=0 and instr_ID<=NOP_INSTR; pc fields hold.
- Redirect (pc_next_sel=1) has highest priority, over stall_IF, gnt and rvalid:
  - pc <= branch_jump_addr.
  - valid_ID <= 0 and instr_ID <= NOP_INSTR, even when stalled.
  - Hold buffer is discarded.
  - Next state by current state:
    - REQ with gnt: DROP (request for the old pc is in flight)
    - REQ without gnt: REQ (imem_addr changes next cycle)
    - WAIT with rvalid: REQ (response discarded)
    - WAIT without rvalid: DROP
    - HOLD: REQ
    - DROP: DROP (pc updated again)
- Arithmetic: PC math is 32-bit modulo; 0xFFFF_FFFC+4 = 0x0000_0000.
- Reset mid-transaction: state returns to REQ. The memory side is reset with the same rst, so no response is pending after reset.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN
- Defined, and a redirect target has addr[1:0] != 2'b00:
  - fetch_misalign <= 1 (sticky until reset); the PC is not loaded.
  - IF/ID is flushed as for a normal redirect.
  - Block enters HALT: imem_req=0, any in-flight response is discarded, valid_ID stays 0 until reset.
  - An aligned redirect in the same or a later cycle has no effect while halted.
- Undefined: target bits [1:0] are forced to 2'b00 on load; fetch_misalign is tied 0; no HALT state.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, rdata=addr^32'hA5A5_0000 -> pc_ID sequence 0,4,8,… with valid_ID=1 every other cycle; instr_ID matches.
- stall_IF held 3 cycles at rvalid for pc=8 -> IF/ID holds the pc=4 entry; after release, pc_ID=8 with the captured rdata; no request issued during the stall.
- Redirect to 0x100 while in WAIT with rvalid delayed 3 cycles -> late response discarded, valid_ID=0, next imem_addr=0x100, next pc_ID=0x100.
- Redirect to 0x200 in the same cycle as rvalid and stall_IF=1 -> valid_ID=0 next cycle, data dropped, next imem_addr=0x200.
- Redirect to 0xFFFF_FFFC -> pc_ID=0xFFFF_FFFC, pcPlus4_ID=0, next imem_addr=0.
- FETCH_MISALIGN_CHK_EN defined, redirect to 0x102 -> fetch_misalign=1, imem_req stays 0, valid_ID=0 until rst; undefined -> next imem_addr=0x100.
